instr_fetch_ctrl: RTL and testbench

//  Sequences the instruction ROM for the single-cycle/pipelined MIPS core.
//  - Owns the PC and drives the ROM word address; the ROM read is combinational.
//  - Registers the ROM word into a valid/ready output stage toward decode.
//  - Handles branch/jump redirects, halt requests, and out-of-range and misaligned-PC faults.

---
 rtl/mips_pkg.sv | 18 +
 rtl/fetch_out_reg.sv | 42 ++++
 rtl/instr_fetch_ctrl.sv | 107 ++++++++++
 tb/tb_instr_fetch_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction fetch path.
package mips_pkg;
  localparam int          WORD_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_HALT,
    ST_FAULT
  } fetch_state_t;

  // Byte PC to ROM word index.
  function automatic logic [WORD_W-1:0] word_idx(input logic [WORD_W-1:0] pc);
    return {2'b00, pc[WORD_W-1:2]};
  endfunction
endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output stage holding one fetched instruction and its PC.
module fetch_out_reg
  import mips_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic              ready_i,
  input  logic [WORD_W-1:0] instr_i,
  input  logic [WORD_W-1:0] pc_i,
  output logic              valid_o,
  output logic [WORD_W-1:0] instr_o,
  output logic [WORD_W-1:0] pc_o
);
  logic              valid_q;
  logic [WORD_W-1:0] instr_q;
  logic [WORD_W-1:0] pc_q;

  // Flush beats load; a consumed word with nothing behind it drops valid so
  // decode never sees the same word twice. Data only changes on load, which
  // the controller only asserts when the slot is free.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, addresses the ROM and feeds decode.
module instr_fetch_ctrl
  import mips_pkg::*;
#(
  parameter int          ROM_DEPTH = 32,
  parameter logic [31:0] PC_RESET  = 32'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        halt_req,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_q,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        busy,
  output logic        halted,
  output logic        fault
);
  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pend_q, pend_d;   // range fault waiting for the output to drain
  logic         issue, flush;
  logic         out_of_range;

  assign out_of_range = word_idx(pc_q) >= 32'(ROM_DEPTH);

  // State, PC and pending-fault registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_RESET;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  // Next state: redirect outranks range check, which outranks halt and issue.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    issue   = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT, ST_FAULT: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = PC_RESET;
          pend_d  = 1'b0;
          flush   = 1'b1;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (|redirect_pc[1:0]) begin
            state_d = ST_FAULT;
            pend_d  = 1'b0;
          end else begin
            pc_d = redirect_pc;
            if (state_q == ST_RUN && halt_req) state_d = ST_HALT;
          end
        end else if (state_q == ST_DRAIN) begin
          if (!instr_valid || instr_ready) begin
            state_d = pend_q ? ST_FAULT : ST_HALT;
            pend_d  = 1'b0;
          end
        end else if (out_of_range) begin
          state_d = ST_DRAIN;
          pend_d  = 1'b1;
        end else if (halt_req) begin
          state_d = ST_DRAIN;
        end else if (!instr_valid || instr_ready) begin
          issue = 1'b1;
          pc_d  = pc_q + PC_STEP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  fetch_out_reg u_out (
    .clk_i   (clock),
    .rst_n_i (reset_n),
    .load_i  (issue),
    .flush_i (flush),
    .ready_i (instr_ready),
    .instr_i (rom_q),
    .pc_i    (pc_q),
    .valid_o (instr_valid),
    .instr_o (instr_out),
    .pc_o    (pc_out)
  );

  assign rom_addr = (state_q == ST_RUN) ? word_idx(pc_q) : '0;
  assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign halted   = (state_q == ST_HALT);
  assign fault    = (state_q == ST_FAULT);
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus random traffic.
module tb_instr_fetch_ctrl;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_ready = 1'b1;
  logic [31:0] rom_addr, rom_q, instr_out, pc_out;
  logic        instr_valid, busy, halted, fault;

  int tests = 0;
  int fails = 0;

  logic [31:0] rom [0:31];

  always #5 clock = ~clock;

  assign rom_q = (rom_addr < 32'd32) ? rom[rom_addr[4:0]] : 32'hDEAD_BEEF;

  instr_fetch_ctrl #(.ROM_DEPTH(32), .PC_RESET(32'h0)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_q          (rom_q),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .busy           (busy),
    .halted         (halted),
    .fault          (fault)
  );

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3, M_FAULT = 4;
  int          m_mode = M_IDLE;
  logic [31:0] m_pc = 0, m_instr = 0, m_pcout = 0;
  bit          m_vld = 0, m_pend = 0, m_live = 0;

  task automatic model_step();
    bit acc;
    if (!reset_n) begin
      m_mode = M_IDLE; m_pc = 0; m_vld = 0; m_instr = 0; m_pcout = 0; m_pend = 0;
      m_live = 1;
      return;
    end
    acc = m_vld && instr_ready;
    if (m_mode == M_IDLE || m_mode == M_HALT || m_mode == M_FAULT) begin
      if (start) begin m_mode = M_RUN; m_pc = 0; m_vld = 0; m_pend = 0; end
    end else if (redirect_valid) begin
      m_vld = 0;
      if (redirect_pc % 4 != 0) begin m_mode = M_FAULT; m_pend = 0; end
      else begin
        m_pc = redirect_pc;
        if (m_mode == M_RUN && halt_req) m_mode = M_HALT;
      end
    end else if (m_mode == M_DRAIN) begin
      if (!m_vld || acc) begin m_vld = 0; m_mode = m_pend ? M_FAULT : M_HALT; m_pend = 0; end
    end else if (m_pc / 4 >= 32) begin
      m_mode = M_DRAIN; m_pend = 1; if (acc) m_vld = 0;
    end else if (halt_req) begin
      m_mode = M_DRAIN; if (acc) m_vld = 0;
    end else if (!m_vld || instr_ready) begin
      m_instr = rom[m_pc / 4]; m_pcout = m_pc; m_vld = 1; m_pc = m_pc + 4;
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clock);
    if (m_live) begin
      logic [31:0] e_addr;
      bit ok;
      e_addr = (m_mode == M_RUN) ? m_pc / 4 : 32'd0;
      ok = (instr_valid === m_vld) && (instr_out === m_instr) && (pc_out === m_pcout) &&
           (rom_addr === e_addr) && (busy === (m_mode == M_RUN || m_mode == M_DRAIN)) &&
           (halted === (m_mode == M_HALT)) && (fault === (m_mode == M_FAULT));
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL model t=%0t got v=%b i=%h p=%h a=%h b=%b h=%b f=%b exp v=%b i=%h p=%h a=%h mode=%0d",
                 $time, instr_valid, instr_out, pc_out, rom_addr, busy, halted, fault,
                 m_vld, m_instr, m_pcout, e_addr, m_mode);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic restart();
    start = 0; halt_req = 0; redirect_valid = 0; instr_ready = 1;
    reset_n = 0; step(); step();
    reset_n = 1; start = 1; step();
    start = 0; step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] exp_w [0:4];
    bit found;
    exp_w[0] = 32'h8C010000; exp_w[1] = 32'h8C020001; exp_w[2] = 32'h8C040002;
    exp_w[3] = 32'h00221820; exp_w[4] = 32'hAC030003;
    for (int i = 0; i < 32; i++) rom[i] = (i < 5) ? exp_w[i] : $urandom;

    // reset state
    step(); step();
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_flags", {29'd0, busy, halted, fault}, 32'd0);

    // 1: streaming, one word per cycle
    reset_n = 1; start = 1; step();
    start = 0;
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_novalid", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t1_w%0d", i), instr_out, exp_w[i]);
      chk($sformatf("t1_pc%0d", i), pc_out, 32'(i * 4));
    end

    // 2: backpressure on the word at pc 8
    restart();
    step(); step();
    instr_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_w", instr_out, 32'h8C040002);
      chk("t2_hold_pc", pc_out, 32'h8);
    end
    instr_ready = 1; step();
    chk("t2_next_w", instr_out, 32'h00221820);
    chk("t2_next_pc", pc_out, 32'hC);

    // 3: redirect to 0x4 flushes, then target word
    redirect_valid = 1; redirect_pc = 32'h4; step();
    redirect_valid = 0;
    chk("t3_flush", {31'd0, instr_valid}, 32'd0);
    step();
    chk("t3_w", instr_out, 32'h8C020001);
    chk("t3_pc", pc_out, 32'h4);

    // 4: misaligned redirect faults; start clears and refetches
    redirect_valid = 1; redirect_pc = 32'h6; step();
    redirect_valid = 0;
    chk("t4_fault", {30'd0, fault, busy}, 32'b10);
    start = 1; step();
    start = 0;
    chk("t4_clear", {30'd0, fault, busy}, 32'b01);
    step();
    chk("t4_w", instr_out, 32'h8C010000);
    chk("t4_pc", pc_out, 32'h0);

    // 5: run off the end of the ROM
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (instr_valid && pc_out == 32'h7C) found = 1;
      else step();
    end
    chk("t5_reach7C", {31'd0, found}, 32'd1);
    chk("t5_lastw", instr_out, rom[31]);
    step();
    chk("t5_drain", {29'd0, instr_valid, busy, fault}, 32'b010);
    step();
    chk("t5_fault", {29'd0, instr_valid, busy, fault}, 32'b001);
    chk("t5_pc_no80", pc_out, 32'h7C);

    // 6: halt with output stalled
    start = 1; step();
    start = 0; instr_ready = 0; step();
    chk("t6_w", instr_out, 32'h8C010000);
    halt_req = 1; step();
    halt_req = 0;
    chk("t6_drain", {29'd0, instr_valid, busy, halted}, 32'b110);
    step();
    chk("t6_hold", instr_out, 32'h8C010000);
    instr_ready = 1; step();
    chk("t6_halted", {29'd0, instr_valid, busy, halted}, 32'b001);
    start = 1; step();
    start = 0; step();
    chk("t6_resume_w", instr_out, 32'h8C010000);
    chk("t6_resume_pc", pc_out, 32'h0);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset_n        = ($urandom_range(0, 299) != 0);
      start          = ($urandom_range(0, 19) == 0);
      halt_req       = ($urandom_range(0, 39) == 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = 32'($urandom_range(0, 36)) << 2;
      if ($urandom_range(0, 7) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      instr_ready    = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
